ahb_txn_arbiter: RTL and testbench



---
 rtl/ahb_txn_arbiter_if.sv | 46 ++++
 rtl/ahb_txn_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_ahb_txn_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_txn_arbiter_if.sv
// Requester command/response channels plus the AHB-Lite master bus of ahb_txn_arbiter.
interface ahb_txn_arbiter_if;
    localparam int unsigned N_REQ = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 3;

    logic [N_REQ-1:0]    REQ_VALID;
    logic [N_REQ-1:0]    REQ_READY;
    logic [N_REQ-1:0]    REQ_WRITE;
    logic [N_REQ-1:0]    REQ_LOCK;
    logic [N_REQ*AW-1:0] REQ_ADDR;
    logic [N_REQ*SW-1:0] REQ_SIZE;
    logic [N_REQ*DW-1:0] REQ_WDATA;
    logic [N_REQ-1:0]    RSP_VALID;
    logic                RSP_ERR;
    logic [DW-1:0]       RSP_RDATA;
    logic [N_REQ-1:0]    GRANT;
    logic [AW-1:0]       HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [SW-1:0]       HSIZE;
    logic [2:0]          HBURST;
    logic [3:0]          HPROT;
    logic                HMASTLOCK;
    logic [DW-1:0]       HWDATA;
    logic [DW-1:0]       HRDATA;
    logic                HREADY;
    logic                HRESP;

    // Arbiter side: consumes commands and slave responses, drives the bus.
    modport master (
        input  REQ_VALID, REQ_WRITE, REQ_LOCK, REQ_ADDR, REQ_SIZE, REQ_WDATA,
        input  HRDATA, HREADY, HRESP,
        output REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA, GRANT,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    // Environment side: requesters and the AHB-Lite slave.
    modport slave (
        output REQ_VALID, REQ_WRITE, REQ_LOCK, REQ_ADDR, REQ_SIZE, REQ_WDATA,
        output HRDATA, HREADY, HRESP,
        input  REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA, GRANT,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/ahb_txn_arbiter.sv
// Two-requester round-robin scheduler issuing single NONSEQ transfers on one AHB-Lite master port.
module ahb_txn_arbiter (
    input  logic              HCLK,
    input  logic              HRESETN,
    ahb_txn_arbiter_if.master bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 3;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RSP} state_e;

    state_e          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            last_q, last_d;          // requester served most recently; owns a held lock
    logic            lock_hold_q, lock_hold_d;
    logic            cmd_write_q, cmd_write_d;
    logic            cmd_lock_q, cmd_lock_d;
    logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
    logic [SW-1:0]   cmd_size_q, cmd_size_d;
    logic [DW-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [AW-1:0]   haddr_q, haddr_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic [SW-1:0]   hsize_q, hsize_d;
    logic            hmastlock_q, hmastlock_d;
    logic [DW-1:0]   hwdata_q, hwdata_d;
    logic [1:0]      req_ready_c;

    logic            pick_vld;
    logic            pick_idx;
    logic [AW-1:0]   sel_addr;
    logic [SW-1:0]   sel_size;
    logic            sel_misaligned;

    // Round-robin pick; a held lock restricts eligibility to its owner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 1'b0;
        if (lock_hold_q) begin
            pick_vld = bus.REQ_VALID[last_q];
            pick_idx = last_q;
        end else if (&bus.REQ_VALID) begin
            pick_vld = 1'b1;
            pick_idx = ~last_q;
        end else if (bus.REQ_VALID[1]) begin
            pick_vld = 1'b1;
            pick_idx = 1'b1;
        end else if (bus.REQ_VALID[0]) begin
            pick_vld = 1'b1;
            pick_idx = 1'b0;
        end
    end

    // Selected requester's address/size and its alignment check.
    always_comb begin
        sel_addr       = pick_idx ? bus.REQ_ADDR[2*AW-1:AW] : bus.REQ_ADDR[AW-1:0];
        sel_size       = pick_idx ? bus.REQ_SIZE[2*SW-1:SW] : bus.REQ_SIZE[SW-1:0];
        sel_misaligned = (sel_size > 3'd2)
                       || ((sel_size == 3'd1) && sel_addr[0])
                       || ((sel_size == 3'd2) && (sel_addr[1:0] != 2'b00));
    end

    // Next state, command capture and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        lock_hold_d = lock_hold_q;
        cmd_write_d = cmd_write_q;
        cmd_lock_d  = cmd_lock_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_size_d  = cmd_size_q;
        cmd_wdata_d = cmd_wdata_q;
        rsp_valid_d = 2'b00;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        haddr_d     = '0;
        htrans_d    = HTRANS_IDLE;
        hwrite_d    = 1'b0;
        hsize_d     = '0;
        hmastlock_d = 1'b0;
        hwdata_d    = '0;
        req_ready_c = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (HRESETN && pick_vld) begin
                    req_ready_c[pick_idx] = 1'b1;
                    cmd_write_d = bus.REQ_WRITE[pick_idx];
                    cmd_lock_d  = bus.REQ_LOCK[pick_idx];
                    cmd_addr_d  = sel_addr;
                    cmd_size_d  = sel_size;
                    cmd_wdata_d = pick_idx ? bus.REQ_WDATA[2*DW-1:DW] : bus.REQ_WDATA[DW-1:0];
                    grant_d     = pick_idx ? 2'b10 : 2'b01;
                    if (sel_misaligned) begin
                        state_d     = S_RSP;
                        rsp_valid_d = pick_idx ? 2'b10 : 2'b01;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (bus.HREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.HREADY) begin
                    state_d     = S_RSP;
                    rsp_valid_d = grant_q;
                    rsp_err_d   = bus.HRESP;
                    rsp_rdata_d = (!cmd_write_q && !bus.HRESP) ? bus.HRDATA : '0;
                end
            end
            S_RSP: begin
                state_d     = S_IDLE;
                grant_d     = 2'b00;
                last_d      = grant_q[1];
                lock_hold_d = cmd_lock_q && !rsp_err_q;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE: hmastlock_d = lock_hold_d;
            S_ADDR: begin
                htrans_d    = HTRANS_NONSEQ;
                haddr_d     = cmd_addr_d;
                hwrite_d    = cmd_write_d;
                hsize_d     = cmd_size_d;
                hmastlock_d = cmd_lock_d || lock_hold_d;
            end
            S_DATA: begin
                hwdata_d    = cmd_write_d ? cmd_wdata_d : '0;
                hmastlock_d = cmd_lock_d || lock_hold_d;
            end
            default: hmastlock_d = 1'b0;
        endcase
    end

    // State, command and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            lock_hold_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_lock_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_size_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hmastlock_q <= 1'b0;
            hwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            lock_hold_q <= lock_hold_d;
            cmd_write_q <= cmd_write_d;
            cmd_lock_q  <= cmd_lock_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_size_q  <= cmd_size_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hmastlock_q <= hmastlock_d;
            hwdata_q    <= hwdata_d;
        end
    end

    assign bus.REQ_READY = req_ready_c;
    assign bus.GRANT     = grant_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.RSP_RDATA = rsp_rdata_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = hmastlock_q;
    assign bus.HWDATA    = hwdata_q;
endmodule

// File: tb/tb_ahb_txn_arbiter.sv
// Bench for ahb_txn_arbiter: transaction-plan model checked every cycle, plus directed literal checks.
module tb_ahb_txn_arbiter;
    localparam int unsigned N_RAND = 3000;

    logic HCLK = 1'b0;
    logic HRESETN;

    ahb_txn_arbiter_if bus ();

    ahb_txn_arbiter dut (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .bus     (bus.master)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one in-flight transaction described by its plan and the cycle count since accept.
    bit          m_chk_en = 1'b0;
    bit          m_busy = 1'b0;
    int          m_k = 0;
    bit          m_last = 1'b1;
    bit          m_lock_hold = 1'b0;
    int          m_owner = 0;
    bit          m_write, m_lock, m_mis, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_size;
    int          m_a, m_d;
    int          n_acc [2];

    // Slave plan forced by directed tests (address waits, data waits, error, read data).
    bit          f_en = 1'b0;
    int          f_a = 0, f_d = 0;
    bit          f_err = 1'b0;
    logic [31:0] f_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 idle, 1 address phase, 2 data phase, 3 response cycle
    function automatic int phase();
        if (!m_busy) return 0;
        if (m_mis) return 3;
        if (m_k <= m_a + 1) return 1;
        if (m_k <= m_a + m_d + 2) return 2;
        return 3;
    endfunction

    function automatic int pick();
        logic [1:0] v;
        v = bus.REQ_VALID;
        if (m_lock_hold) return v[m_last] ? int'(m_last) : -1;
        if (v == 2'b11) return m_last ? 0 : 1;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    task automatic set_req(input int r, input bit v, input bit w, input bit l,
                           input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        bus.REQ_VALID[r]          = v;
        bus.REQ_WRITE[r]          = w;
        bus.REQ_LOCK[r]           = l;
        bus.REQ_ADDR[r*32 +: 32]  = a;
        bus.REQ_SIZE[r*3 +: 3]    = s;
        bus.REQ_WDATA[r*32 +: 32] = d;
    endtask

    // One clock cycle: drive slave, compare all outputs with the model, advance model over the edge.
    task automatic cycle();
        int ph, j, p;
        logic [1:0]  e_ready, e_grant, e_rv, own;
        logic        e_err, e_hwrite, e_lock;
        logic [31:0] e_rdata, e_haddr, e_hwdata;
        logic [1:0]  e_htrans;
        logic [2:0]  e_hsize;

        ph = phase();
        bus.HREADY = 1'($urandom);
        bus.HRESP  = 1'($urandom);
        bus.HRDATA = $urandom;
        if (ph == 1) begin
            bus.HREADY = (m_k == m_a + 1);
            bus.HRESP  = 1'b0;
        end else if (ph == 2) begin
            j = m_k - m_a - 1;
            bus.HREADY = (j == m_d + 1);
            bus.HRESP  = m_err && (j >= m_d);
            if (j == m_d + 1) bus.HRDATA = m_rdata;
        end
        #1;
        p   = pick();
        own = (m_owner == 1) ? 2'b10 : 2'b01;
        e_ready  = (!m_busy && HRESETN && p >= 0) ? ((p == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_grant  = 2'b00;
        e_rv     = 2'b00;
        e_err    = 1'b0;
        e_rdata  = '0;
        e_htrans = 2'b00;
        e_haddr  = '0;
        e_hwrite = 1'b0;
        e_hsize  = '0;
        e_hwdata = '0;
        e_lock   = m_lock_hold;
        case (ph)
            1: begin
                e_grant  = own;
                e_htrans = 2'b10;
                e_haddr  = m_addr;
                e_hwrite = m_write;
                e_hsize  = m_size;
                e_lock   = m_lock || m_lock_hold;
            end
            2: begin
                e_grant  = own;
                e_hwdata = m_write ? m_wdata : 32'h0;
                e_lock   = m_lock || m_lock_hold;
            end
            3: begin
                e_grant = own;
                e_rv    = own;
                e_err   = m_mis || m_err;
                e_rdata = (!m_write && !(m_mis || m_err)) ? m_rdata : 32'h0;
                e_lock  = 1'b0;
            end
            default: ;
        endcase
        if (m_chk_en) begin
            check("req_ready", 32'(bus.REQ_READY), 32'(e_ready));
            check("grant",     32'(bus.GRANT),     32'(e_grant));
            check("rsp_valid", 32'(bus.RSP_VALID), 32'(e_rv));
            check("rsp_err",   32'(bus.RSP_ERR),   32'(e_err));
            check("rsp_rdata", bus.RSP_RDATA,      e_rdata);
            check("htrans",    32'(bus.HTRANS),    32'(e_htrans));
            check("haddr",     bus.HADDR,          e_haddr);
            check("hwrite",    32'(bus.HWRITE),    32'(e_hwrite));
            check("hsize",     32'(bus.HSIZE),     32'(e_hsize));
            check("hwdata",    bus.HWDATA,         e_hwdata);
            check("hmastlock", 32'(bus.HMASTLOCK), 32'(e_lock));
            check("hburst",    32'(bus.HBURST),    32'h0);
            check("hprot",     32'(bus.HPROT),     32'h3);
        end
        if (!HRESETN) begin
            m_busy      = 1'b0;
            m_lock_hold = 1'b0;
            m_last      = 1'b1;
            m_chk_en    = 1'b1;
        end else if (m_busy) begin
            if (ph == 3) begin
                m_lock_hold = m_lock && !(m_mis || m_err);
                m_last      = 1'(m_owner);
                m_busy      = 1'b0;
            end else begin
                m_k++;
            end
        end else if (p >= 0) begin
            m_owner = p;
            m_write = bus.REQ_WRITE[p];
            m_lock  = bus.REQ_LOCK[p];
            m_addr  = bus.REQ_ADDR[p*32 +: 32];
            m_size  = bus.REQ_SIZE[p*3 +: 3];
            m_wdata = bus.REQ_WDATA[p*32 +: 32];
            m_mis   = (m_size > 3'd2) || (m_size == 3'd1 && m_addr[0])
                   || (m_size == 3'd2 && m_addr[1:0] != 2'b00);
            if (f_en) begin
                m_a = f_a; m_d = f_d; m_err = f_err; m_rdata = f_rdata;
            end else begin
                m_a     = ($urandom % 6 == 0) ? int'($urandom_range(1, 2)) : 0;
                m_d     = int'($urandom_range(0, 3));
                m_err   = ($urandom % 6 == 0);
                m_rdata = $urandom;
            end
            if (m_err && m_d == 0) m_d = 1;
            if (m_mis) m_err = 1'b0;
            m_busy = 1'b1;
            m_k    = 1;
            n_acc[p]++;
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        logic [31:0] qa[$];
        logic        ql[$];
        logic [31:0] exp_alt [4];
        logic [1:0]  exp_gnt [4];
        logic [1:0]  qg[$];
        logic [31:0] exp_lk [3];
        logic        exp_ll [3];

        HRESETN = 1'b0;
        bus.REQ_VALID = '0; bus.REQ_WRITE = '0; bus.REQ_LOCK = '0;
        bus.REQ_ADDR = '0;  bus.REQ_SIZE = '0;  bus.REQ_WDATA = '0;
        bus.HRDATA = '0;    bus.HREADY = 1'b1;  bus.HRESP = 1'b0;
        n_acc[0] = 0; n_acc[1] = 0;

        // Reset with both requesters valid
        bus.REQ_VALID = 2'b11;
        cycle();
        cycle();
        check("rst_ready", 32'(bus.REQ_READY), 32'h0);
        check("rst_grant", 32'(bus.GRANT), 32'h0);
        check("rst_hprot", 32'(bus.HPROT), 32'h3);
        check("rst_htrans", 32'(bus.HTRANS), 32'h0);
        HRESETN = 1'b1;
        bus.REQ_VALID = 2'b00;
        cycle();

        // Single write, zero wait
        f_en = 1'b1; f_a = 0; f_d = 0; f_err = 1'b0; f_rdata = '0;
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h4000_0004, 3'd2, 32'hA5A5_0001);
        cycle();
        bus.REQ_VALID = 2'b00;
        check("wr_htrans_c1", 32'(bus.HTRANS), 32'h2);
        check("wr_haddr_c1", bus.HADDR, 32'h4000_0004);
        cycle();
        check("wr_hwdata_c2", bus.HWDATA, 32'hA5A5_0001);
        cycle();
        check("wr_rspv_c3", 32'(bus.RSP_VALID), 32'h1);
        check("wr_rsperr_c3", 32'(bus.RSP_ERR), 32'h0);
        cycle();

        // Read with two data-phase wait states
        f_d = 2; f_rdata = 32'h1234_5678;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h4000_0008, 3'd2, 32'h0);
        cycle();
        bus.REQ_VALID = 2'b00;
        repeat (3) cycle();
        check("rd_no_rsp_c4", 32'(bus.RSP_VALID), 32'h0);
        cycle();
        check("rd_rspv_c5", 32'(bus.RSP_VALID), 32'h1);
        check("rd_rdata_c5", bus.RSP_RDATA, 32'h1234_5678);
        cycle();

        // Both valid continuously: alternation from a fresh reset
        f_d = 0; f_rdata = 32'h0;
        HRESETN = 1'b0;
        cycle();
        HRESETN = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 3'd2, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 3'd2, 32'h0);
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (bus.HTRANS == 2'b10) begin
                qa.push_back(bus.HADDR);
                qg.push_back(bus.GRANT);
            end
        end
        bus.REQ_VALID = 2'b00;
        exp_alt = '{32'h100, 32'h200, 32'h100, 32'h200};
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        check("alt_count", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("alt_haddr", (i < qa.size()) ? qa[i] : 32'hxxxx_xxxx, exp_alt[i]);
            check("alt_grant", (i < qg.size()) ? 32'(qg[i]) : 32'hxxxx_xxxx, 32'(exp_gnt[i]));
        end
        cycle();

        // Locked pair from req1 blocks req0
        HRESETN = 1'b0;
        cycle();
        HRESETN = 1'b1;
        n_acc[0] = 0; n_acc[1] = 0;
        qa.delete();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 3'd2, 32'h0);
        for (int c = 0; c < 40; c++) begin
            set_req(1, n_acc[1] < 2, 1'b1, n_acc[1] == 0,
                    (n_acc[1] == 0) ? 32'h0000_0300 : 32'h0000_0304, 3'd2, 32'h11);
            bus.REQ_VALID[0] = (n_acc[1] >= 1) && (n_acc[0] == 0);
            cycle();
            if (bus.HTRANS == 2'b10) begin
                qa.push_back(bus.HADDR);
                ql.push_back(bus.HMASTLOCK);
            end
        end
        bus.REQ_VALID = 2'b00;
        exp_lk = '{32'h300, 32'h304, 32'h100};
        exp_ll = '{1'b1, 1'b1, 1'b0};
        check("lock_count", 32'(qa.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("lock_haddr", (i < qa.size()) ? qa[i] : 32'hxxxx_xxxx, exp_lk[i]);
            check("lock_hmastlock", (i < ql.size()) ? 32'(ql[i]) : 32'hxxxx_xxxx, 32'(exp_ll[i]));
        end

        // Misaligned word access is rejected without a bus transfer
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h4000_0002, 3'd2, 32'h0);
        cycle();
        bus.REQ_VALID = 2'b00;
        check("mis_htrans", 32'(bus.HTRANS), 32'h0);
        check("mis_rspv", 32'(bus.RSP_VALID), 32'h1);
        check("mis_rsperr", 32'(bus.RSP_ERR), 32'h1);
        cycle();

        // Two-cycle error response on a locked read clears the lock
        f_d = 1; f_err = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b1, 32'h4000_0010, 3'd2, 32'h0);
        cycle();
        bus.REQ_VALID = 2'b00;
        repeat (3) cycle();
        check("err_rspv", 32'(bus.RSP_VALID), 32'h1);
        check("err_rsperr", 32'(bus.RSP_ERR), 32'h1);
        check("err_rdata", bus.RSP_RDATA, 32'h0);
        cycle();
        check("err_lock_cleared", 32'(bus.HMASTLOCK), 32'h0);

        // Reset during the data phase aborts silently
        f_d = 3; f_err = 1'b0;
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h4000_0020, 3'd2, 32'hDEAD_BEEF);
        cycle();
        bus.REQ_VALID = 2'b00;
        cycle();
        check("abort_in_data", bus.HWDATA, 32'hDEAD_BEEF);
        HRESETN = 1'b0;
        cycle();
        check("abort_htrans", 32'(bus.HTRANS), 32'h0);
        check("abort_grant", 32'(bus.GRANT), 32'h0);
        HRESETN = 1'b1;
        repeat (5) cycle();
        check("abort_no_rsp", 32'(bus.RSP_VALID), 32'h0);

        // Randomized traffic with occasional resets
        f_en = 1'b0;
        for (int c = 0; c < int'(N_RAND); c++) begin
            for (int r = 0; r < 2; r++) begin
                logic [31:0] a;
                logic [2:0]  s;
                a = $urandom;
                if ($urandom % 4 != 0) a[1:0] = 2'b00;
                s = ($urandom % 8 == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
                set_req(r, ($urandom % 4) != 0, 1'($urandom), ($urandom % 5) == 0, a, s, $urandom);
            end
            HRESETN = ($urandom % 300) != 0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
